branch_target_buffer: RTL

- Parametrised branch target buffer with per-entry saturating direction counters, feeding next-PC selection in the fetch stage of the pipelined MIPS core.
- The fetch stage looks it up with the current PC; the execute stage updates it with the resolved branch or jump outcome.
- Replaces the fixed "predict not-taken, redirect from EX" scheme with a configurable static or dynamic predictor.
- Provides a multi-cycle invalidate sweep and saturating statistics counters.

---
 rtl/branch_target_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Branch target buffer for the fetch stage: direct-mapped table of
// {valid, tag, target, direction counter}, looked up combinationally by
// fetch and trained by execute. Includes a one-entry-per-cycle
// invalidate sweep and saturating update/mispredict statistics.
module branch_target_buffer #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int DYNAMIC  = 1,
    parameter int STAT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              update_en,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              flush_req,
    output logic              busy,
    output logic [STAT_W-1:0] update_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Weakly-taken on allocation, weakly-not-taken after reset/sweep.
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic                DYN_EN  = (DYNAMIC != 0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [STAT_W-1:0] update_cnt_q, update_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit, u_pred, upd_acc;
    logic             unused_pc_bits;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign busy = (state_q == ST_SWEEP);

    // Fetch-side lookup from registered state; no bypass of same-cycle updates.
    always_comb begin
        pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && !busy;
        pred_taken  = pred_hit && DYN_EN && ctr_q[l_idx][CTR_BITS-1];
        pred_target = pred_hit ? target_q[l_idx] : 32'h0;
    end

    // Prediction the table would give the updating instruction, pre-update.
    always_comb begin
        upd_acc = update_en && !busy;
        u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_pred  = u_hit && DYN_EN && ctr_q[u_idx][CTR_BITS-1];
    end

    // Table next-state: execute-stage training, or one entry cleared per sweep cycle.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_acc) begin
            if (u_hit) begin
                if (update_taken) begin
                    if (ctr_q[u_idx] != CTR_MAX) ctr_d[u_idx] = ctr_q[u_idx] + CTR_BITS'(1);
                    target_d[u_idx] = update_target;
                end else begin
                    if (ctr_q[u_idx] != '0) ctr_d[u_idx] = ctr_q[u_idx] - CTR_BITS'(1);
                end
            end else if (update_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = update_target;
                ctr_d[u_idx]    = CTR_WT;
            end
        end
        if (busy) begin
            valid_d[sweep_ptr_q] = 1'b0;
            ctr_d[sweep_ptr_q]   = CTR_WNT;
        end
    end

    // Sweep FSM; a flush request while sweeping is ignored.
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d     = ST_SWEEP;
                    sweep_ptr_d = '0;
                end
            end
            ST_SWEEP: begin
                sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
                if (sweep_ptr_q == LAST_IDX) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating statistics over accepted updates only.
    always_comb begin
        update_cnt_d  = update_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_acc) begin
            if (update_cnt_q != '1) update_cnt_d = update_cnt_q + STAT_W'(1);
            if ((update_taken != u_pred) && (mispred_cnt_q != '1))
                mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
        end
    end

    assign update_cnt  = update_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q       <= '0;
            state_q       <= ST_IDLE;
            sweep_ptr_q   <= '0;
            update_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            state_q       <= state_d;
            sweep_ptr_q   <= sweep_ptr_d;
            update_cnt_q  <= update_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule
